// File: rtl/qspi_ram_pkg.sv
// Shared opcodes and FSM state type for the QSPI RAM peripheral.
package qspi_ram_pkg;

   localparam logic [7:0] CMD_READ   = 8'h03;
   localparam logic [7:0] CMD_WRITE  = 8'h02;
   localparam logic [7:0] CMD_QREAD  = 8'h6B;
   localparam logic [7:0] CMD_QWRITE = 8'h32;
   localparam logic [7:0] CMD_WREN   = 8'h06;
   localparam logic [7:0] CMD_WRDI   = 8'h04;
   localparam logic [7:0] CMD_RDSR   = 8'h05;

   typedef enum logic [2:0] {
      StIdle,
      StCmd,
      StAddr,
      StDummy,
      StRd,
      StWr,
      StIgnore
   } state_t;

endpackage

// File: rtl/spi_in_sync.sv
// Synchronises the SPI pins into the clk domain and produces one-cycle edge pulses.
module spi_in_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       select,
   input  logic [3:0] d_in,
   output logic       sclk_rise,
   output logic       sclk_fall,
   output logic       sel_rise,
   output logic       sel_fall,
   output logic [3:0] d
);

   logic [SYNC_STAGES-1:0]      sclk_sr, sel_sr;
   logic [SYNC_STAGES-1:0][3:0] d_sr;
   logic                        sclk_prev, sel_prev;

   // Select resets low so a select already asserted at reset release is not
   // mistaken for a fresh transaction start.
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sr   <= '0;
         sel_sr    <= '0;
         d_sr      <= '0;
         sclk_prev <= 1'b0;
         sel_prev  <= 1'b0;
      end else begin
         sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], sclk};
         sel_sr    <= {sel_sr[SYNC_STAGES-2:0], select};
         d_sr      <= {d_sr[SYNC_STAGES-2:0], d_in};
         sclk_prev <= sclk_sr[SYNC_STAGES-1];
         sel_prev  <= sel_sr[SYNC_STAGES-1];
      end
   end

   assign sclk_rise = sclk_sr[SYNC_STAGES-1] & ~sclk_prev;
   assign sclk_fall = ~sclk_sr[SYNC_STAGES-1] & sclk_prev;
   assign sel_rise  = sel_sr[SYNC_STAGES-1] & ~sel_prev;
   assign sel_fall  = ~sel_sr[SYNC_STAGES-1] & sel_prev;
   assign d         = d_sr[SYNC_STAGES-1];

endmodule

// File: rtl/qspi_ram_peri_sync.sv
// SPI/QSPI RAM peripheral, fully synchronous to clk, with a registered host read port.
// Optional write protection (WEL, 06h/04h/05h) is enabled by defining QSPI_RAM_PERI_WP_EN.
module qspi_ram_peri_sync
   import qspi_ram_pkg::*;
#(
   parameter int unsigned RAM_ADDR_BITS   = 6,
   parameter int unsigned ADDR_BYTES      = 3,
   parameter int unsigned FAST_READ_DELAY = 2,
   parameter int unsigned SYNC_STAGES     = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     spi_sclk,
   input  logic                     spi_select,
   input  logic [3:0]               spi_d_in,
   output logic [3:0]               spi_d_out,
   output logic [3:0]               spi_d_oe,
   input  logic [RAM_ADDR_BITS-1:0] host_addr,
   output logic [7:0]               host_rdata,
   output logic                     busy
);

   localparam logic [5:0] CNT_ONE = 6'd1;
   localparam logic [5:0] ADDR_LAST = 6'(8 * ADDR_BYTES - 1);
   localparam logic [5:0] DUMMY_LAST = 6'(FAST_READ_DELAY - 1);
   localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE = RAM_ADDR_BITS'(1);

   logic sclk_rise, sclk_fall, sel_rise, sel_fall;
   logic [3:0] d;

   spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .rst      (rst),
      .sclk     (spi_sclk),
      .select   (spi_select),
      .d_in     (spi_d_in),
      .sclk_rise(sclk_rise),
      .sclk_fall(sclk_fall),
      .sel_rise (sel_rise),
      .sel_fall (sel_fall),
      .d        (d)
   );

   state_t                   state_q, state_d;
   logic [7:0]               cmd_q, cmd_d, shift_q, shift_d;
   logic [5:0]               cnt_q, cnt_d;
   logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
   logic [3:0]               d_out_q, d_out_d, oe_q, oe_d;
   logic [7:0]               mem [2**RAM_ADDR_BITS];
   logic [7:0]               rd_data_q, rd_byte, wdata, sh_single, sh_quad;
   logic                     we, wr_ok, quad;

   assign sh_single = {shift_q[6:0], d[0]};
   assign sh_quad   = {shift_q[3:0], d};
   assign quad      = (cmd_q == CMD_QREAD) || (cmd_q == CMD_QWRITE);

`ifdef QSPI_RAM_PERI_WP_EN
   logic wel_q, wel_d;
   assign wr_ok   = wel_q;
   assign rd_byte = (cmd_q == CMD_RDSR) ? {7'b0, wel_q} : rd_data_q;
`else
   assign wr_ok   = 1'b1;
   assign rd_byte = rd_data_q;
`endif

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      d_out_d = d_out_q;
      oe_d    = oe_q;
      we      = 1'b0;
      wdata   = quad ? sh_quad : sh_single;
`ifdef QSPI_RAM_PERI_WP_EN
      wel_d   = wel_q;
`endif
      if (sel_rise) begin
         state_d = StIdle;
         cmd_d   = '0;
         shift_d = '0;
         cnt_d   = '0;
         d_out_d = '0;
         oe_d    = '0;
`ifdef QSPI_RAM_PERI_WP_EN
         if (cmd_q == CMD_WRITE || cmd_q == CMD_QWRITE) wel_d = 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: if (sel_fall) state_d = StCmd;
            StCmd: if (sclk_rise) begin
               shift_d = sh_single;
               cnt_d   = cnt_q + CNT_ONE;
               if (cnt_q == 6'd7) begin
                  cnt_d = '0;
                  cmd_d = sh_single;
                  case (sh_single)
                     CMD_READ, CMD_WRITE, CMD_QREAD, CMD_QWRITE: state_d = StAddr;
`ifdef QSPI_RAM_PERI_WP_EN
                     CMD_WREN: begin wel_d = 1'b1; state_d = StIgnore; end
                     CMD_WRDI: begin wel_d = 1'b0; state_d = StIgnore; end
                     CMD_RDSR: state_d = StRd;
`endif
                     default: state_d = StIgnore;
                  endcase
               end
            end
            // Shifting left keeps only the low RAM_ADDR_BITS of the address.
            StAddr: if (sclk_rise) begin
               addr_d = {addr_q[RAM_ADDR_BITS-2:0], d[0]};
               cnt_d  = cnt_q + CNT_ONE;
               if (cnt_q == ADDR_LAST) begin
                  cnt_d = '0;
                  if (cmd_q == CMD_QREAD)     state_d = StDummy;
                  else if (cmd_q == CMD_READ) state_d = StRd;
                  else                        state_d = StWr;
               end
            end
            StDummy: if (sclk_rise) begin
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_q == DUMMY_LAST) begin
                  cnt_d   = '0;
                  state_d = StRd;
               end
            end
            StRd: if (sclk_fall) begin
               if (quad) begin
                  oe_d    = 4'b1111;
                  d_out_d = cnt_q[0] ? rd_byte[3:0] : rd_byte[7:4];
                  cnt_d   = cnt_q[0] ? 6'd0 : 6'd1;
                  if (cnt_q[0]) addr_d = addr_q + ADDR_ONE;
               end else begin
                  oe_d    = 4'b0010;
                  d_out_d = {2'b00, rd_byte[~cnt_q[2:0]], 1'b0};
                  cnt_d   = cnt_q + CNT_ONE;
                  if (cnt_q == 6'd7) begin
                     cnt_d  = '0;
                     addr_d = addr_q + ADDR_ONE;
                  end
               end
            end
            StWr: if (sclk_rise) begin
               shift_d = quad ? sh_quad : sh_single;
               cnt_d   = cnt_q + CNT_ONE;
               if ((quad && cnt_q[0]) || (!quad && cnt_q == 6'd7)) begin
                  cnt_d  = '0;
                  we     = wr_ok;
                  addr_d = addr_q + ADDR_ONE;
               end
            end
            StIgnore: ;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cmd_q      <= '0;
         shift_q    <= '0;
         cnt_q      <= '0;
         addr_q     <= '0;
         d_out_q    <= '0;
         oe_q       <= '0;
         host_rdata <= '0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         d_out_q    <= d_out_d;
         oe_q       <= oe_d;
         host_rdata <= mem[host_addr];
      end
   end

`ifdef QSPI_RAM_PERI_WP_EN
   always_ff @(posedge clk) begin
      if (rst) wel_q <= 1'b0;
      else     wel_q <= wel_d;
   end
`endif

   // Storage is never reset; rd_data_q tracks addr_q so read data is ready ahead of each fall.
   always_ff @(posedge clk) begin
      if (we) mem[addr_q] <= wdata;
      rd_data_q <= mem[addr_q];
   end

   assign spi_d_out = d_out_q;
   assign spi_d_oe  = oe_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_qspi_ram_peri_sync.sv
// Self-checking bench for qspi_ram_peri_sync: vector table plus a read-data scoreboard.
module tb_qspi_ram_peri_sync;

   localparam int unsigned RAB = 6, AB = 3, FRD = 2, SS = 2, HALF = 4;

   logic       clk = 1'b0, rst, sclk, select;
   logic [3:0] d_in, d_out, d_oe;
   logic [5:0] host_addr;
   logic [7:0] host_rdata;
   logic       busy;

   qspi_ram_peri_sync #(
      .RAM_ADDR_BITS  (RAB),
      .ADDR_BYTES     (AB),
      .FAST_READ_DELAY(FRD),
      .SYNC_STAGES    (SS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .spi_sclk  (sclk),
      .spi_select(select),
      .spi_d_in  (d_in),
      .spi_d_out (d_out),
      .spi_d_oe  (d_oe),
      .host_addr (host_addr),
      .host_rdata(host_rdata),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  op;
      logic [23:0] addr;
      int          n;
      logic [31:0] bytes;
   } vec_t;

   int         vectors = 0, miscompares = 0;
   logic [7:0] sb[$];
   logic [7:0] model [64];
   logic       wel_m = 1'b1;
   vec_t       vec [9];

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %02h, want %02h", name, act, exp);
      end
   endtask

   task automatic sel_low();
      select = 1'b0;
      wait_clk(HALF);
   endtask

   task automatic sel_high();
      wait_clk(HALF);
      select = 1'b1;
      wait_clk(3 * HALF);
   endtask

   task automatic pulse();
      wait_clk(HALF);
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         d_in = {3'b000, b[i]};
         pulse();
      end
   endtask

   task automatic send_nib(input logic [3:0] n);
      d_in = n;
      pulse();
   endtask

   task automatic read_single(output logic [7:0] b, output logic [3:0] oe0);
      for (int i = 7; i >= 0; i--) begin
         wait_clk(HALF);
         b[i] = d_out[1];
         if (i == 7) oe0 = d_oe;
         sclk = 1'b1;
         wait_clk(HALF);
         sclk = 1'b0;
      end
   endtask

   task automatic read_quad(output logic [7:0] b, output logic [3:0] oe0);
      wait_clk(HALF);
      b[7:4] = d_out;
      oe0 = d_oe;
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
      wait_clk(HALF);
      b[3:0] = d_out;
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
   endtask

   task automatic host_check(input logic [5:0] a);
      host_addr = a;
      wait_clk(1);
      check($sformatf("host[%02h]", a), host_rdata, model[a]);
   endtask

   // Deselect must idle the link within SYNC_STAGES+1 clocks.
   task automatic deselect_check(input string name);
      logic ok;
      ok = 1'b0;
      select = 1'b1;
      for (int k = 0; k < SS + 1; k++) begin
         wait_clk(1);
         if (d_oe == 4'b0000 && !busy) ok = 1'b1;
      end
      check(name, 8'(ok), 8'h01);
      wait_clk(2 * HALF);
   endtask

   task automatic apply(input vec_t t);
      logic [7:0] b, exp;
      logic [3:0] oe0;
      logic [5:0] a;
      logic       q;
      sel_low();
      send_byte(t.op);
      for (int i = AB - 1; i >= 0; i--) send_byte(t.addr[8*i +: 8]);
      a = t.addr[5:0];
      q = (t.op == 8'h6B || t.op == 8'h32);
      if (t.op == 8'h02 || t.op == 8'h32) begin
         for (int i = 0; i < t.n; i++) begin
            b = t.bytes[8*(t.n-1-i) +: 8];
            if (q) begin
               send_nib(b[7:4]);
               send_nib(b[3:0]);
            end else begin
               send_byte(b);
            end
            if (wel_m) model[a] = b;
            a++;
         end
         sel_high();
`ifdef QSPI_RAM_PERI_WP_EN
         wel_m = 1'b0;
`endif
         for (int i = 0; i < t.n; i++) host_check(6'(t.addr[5:0] + 6'(i)));
      end else begin
         for (int i = 0; i < t.n; i++) sb.push_back(t.bytes[8*(t.n-1-i) +: 8]);
         if (q) begin
            for (int k = 0; k < FRD; k++) begin
               wait_clk(HALF);
               if (k == FRD - 1) check("oe_in_dummy", 8'(d_oe), 8'h00);
               sclk = 1'b1;
               wait_clk(HALF);
               sclk = 1'b0;
            end
         end
         for (int i = 0; i < t.n; i++) begin
            if (q) read_quad(b, oe0);
            else   read_single(b, oe0);
            if (i == 0) check(q ? "oe_quad" : "oe_single", 8'(oe0), q ? 8'h0F : 8'h02);
            if (sb.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL scoreboard: got %02h, want nothing queued", b);
            end else begin
               exp = sb.pop_front();
               check($sformatf("rd %02h+%0d", t.addr[5:0], i), b, exp);
            end
         end
         sel_high();
      end
   endtask

   task automatic single_cmd(input logic [7:0] op);
      sel_low();
      send_byte(op);
      sel_high();
   endtask

   initial begin
      logic [7:0] b;
      logic [3:0] oe0;

      vec[0] = '{8'h02, 24'h000005, 2, 32'h0000A53C};
      vec[1] = '{8'h03, 24'h000005, 2, 32'h0000A53C};
      vec[2] = '{8'h32, 24'h00003F, 2, 32'h00001234};
      vec[3] = '{8'h6B, 24'h00003F, 2, 32'h00001234};
      vec[4] = '{8'h02, 24'hABCD50, 1, 32'h00000099};
      vec[5] = '{8'h03, 24'h000010, 1, 32'h00000099};
      vec[6] = '{8'h03, 24'h00003F, 2, 32'h00001234};
      vec[7] = '{8'h02, 24'h00003E, 3, 32'h00112233};
      vec[8] = '{8'h6B, 24'h00003E, 3, 32'h00112233};

      rst = 1'b1; select = 1'b1; sclk = 1'b0; d_in = '0; host_addr = '0;
      wait_clk(5);
      check("rst_host_rdata", host_rdata, 8'h00);
      rst = 1'b0;
      wait_clk(1);
      check("rst_oe", 8'(d_oe), 8'h00);
      check("rst_dout", 8'(d_out), 8'h00);
      check("rst_busy", 8'(busy), 8'h00);

`ifdef QSPI_RAM_PERI_WP_EN
      wel_m = 1'b0;
      single_cmd(8'h06);
      wel_m = 1'b1;
      apply('{8'h02, 24'h000020, 1, 32'h00000011});
      apply('{8'h02, 24'h000020, 1, 32'h00000055});
      check("wp_blocked", host_rdata, 8'h11);
      single_cmd(8'h06);
      wel_m = 1'b1;
      sel_low();
      send_byte(8'h05);
      read_single(b, oe0);
      check("rdsr_wel1", b, 8'h01);
      read_single(b, oe0);
      check("rdsr_repeat", b, 8'h01);
      sel_high();
      apply('{8'h02, 24'h000020, 1, 32'h00000077});
      check("wp_written", host_rdata, 8'h77);
      sel_low();
      send_byte(8'h05);
      read_single(b, oe0);
      check("rdsr_after_wr", b, 8'h00);
      sel_high();
      single_cmd(8'h06);
      single_cmd(8'h04);
      wel_m = 1'b1;
      sel_low();
      send_byte(8'h05);
      read_single(b, oe0);
      check("rdsr_wrdi", b, 8'h00);
      sel_high();
      single_cmd(8'h06);
`endif

      for (int v = 0; v < 9; v++) begin
`ifdef QSPI_RAM_PERI_WP_EN
         if (vec[v].op == 8'h02 || vec[v].op == 8'h32) single_cmd(8'h06);
`endif
         apply(vec[v]);
      end
      check("host_wrap_3f", model[6'h3F], 8'h22);
      check("host_wrap_00", model[6'h00], 8'h33);

      // Partial byte then deselect: RAM untouched, link idles promptly.
      sel_low();
      send_byte(8'h02);
      for (int i = AB - 1; i >= 0; i--) send_byte(8'h10 >> (8 * i));
      for (int i = 0; i < 5; i++) begin
         d_in = 4'b0001;
         pulse();
      end
      check("partial_busy", 8'(busy), 8'h01);
      deselect_check("partial_wr_idle");
      host_check(6'h10);

      // Deselect mid read.
      sel_low();
      send_byte(8'h03);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
      wait_clk(HALF);
      check("midread_oe", 8'(d_oe), 8'h02);
      deselect_check("midread_idle");

      // Unknown opcode: nothing driven.
      sel_low();
      send_byte(8'h9F);
      read_single(b, oe0);
      check("ignore_oe", 8'(oe0), 8'h00);
      check("ignore_busy", 8'(busy), 8'h01);
      sel_high();
`ifndef QSPI_RAM_PERI_WP_EN
      sel_low();
      send_byte(8'h05);
      read_single(b, oe0);
      check("rdsr_ignored_oe", 8'(oe0), 8'h00);
      sel_high();
`endif

      // Reset mid transaction, then resync on the next select fall.
      sel_low();
      send_byte(8'h02);
      send_byte(8'h00);
      rst = 1'b1;
      wait_clk(2);
      rst = 1'b0;
      wait_clk(1);
      check("midrst_busy", 8'(busy), 8'h00);
      check("midrst_oe", 8'(d_oe), 8'h00);
      for (int i = 0; i < 4; i++) pulse();
      check("midrst_stay_idle", 8'(busy), 8'h00);
      select = 1'b1;
      wait_clk(3 * HALF);
      apply(vec[1]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
